// File: rtl/ps2_pkg.sv
// ps2_pkg: byte constants, frame layout and state encoding shared by the PS/2 mouse controller.
package ps2_pkg;
  localparam logic [7:0] BAT_OK       = 8'hAA;
  localparam logic [7:0] MOUSE_ID     = 8'h00;
  localparam logic [7:0] EN_REPORTING = 8'hF4;
  localparam logic [7:0] ACK          = 8'hFA;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam int F_START    = 0;
  localparam int F_DATA_LSB = 1;
  localparam int F_DATA_MSB = 8;
  localparam int F_PARITY   = 9;
  localparam int F_STOP     = 10;
  typedef enum logic [2:0] {WAIT_BAT, WAIT_ID, BUSY_CHECK, SEND, WAIT_ACK, STREAM, FAIL} state_t;
  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_axis_accum.sv
// ps2_axis_accum: saturates one packet delta, scales it and accumulates a clamped axis position.
module ps2_axis_accum #(
  parameter int POS_WIDTH   = 10,
  parameter int MAX         = 639,
  parameter int INIT        = 320,
  parameter int SPEED_SHIFT = 0
) (
  input  logic                 clk_25MHz,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 invert,
  input  logic                 sign,
  input  logic                 ovf,
  input  logic [7:0]           mag,
  output logic [8:0]           delta,
  output logic [POS_WIDTH-1:0] pos
);
  localparam int W = POS_WIDTH + 2;
  logic signed [8:0]   sat, sh;
  logic signed [W-1:0] step, cur, sum;
  logic [POS_WIDTH-1:0] clamped;
  always_comb begin
    sat = ovf ? (sign ? 9'h100 : 9'h0FF) : {sign, mag};
    sh = sat >>> SPEED_SHIFT;
    step = W'(sh);
    cur = $signed({2'b00, pos});
    sum = invert ? cur - step : cur + step;
    clamped = sum[W-1] ? '0 : (sum > W'(MAX)) ? POS_WIDTH'(MAX) : sum[POS_WIDTH-1:0];
  end
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      delta <= '0;
      pos <= POS_WIDTH'(INIT);
    end else if (en) begin
      delta <= sat;
      pos <= clamped;
    end
  end
endmodule

// File: rtl/ps2_mouse_ctrl_v2.sv
// ps2_mouse_ctrl_v2: PS/2 mouse power-up handshake with retries, 3-byte packet assembly
// and clamped paddle position tracking.
module ps2_mouse_ctrl_v2 import ps2_pkg::*; #(
  parameter int POS_WIDTH      = 10,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int POS_INIT_X     = 320,
  parameter int POS_INIT_Y     = 240,
  parameter int SPEED_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES     = 50_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk_25MHz,
  input  logic                 reset,
  input  logic [10:0]          rx_data,
  input  logic                 data_available,
  input  logic                 err,
  input  logic                 busy,
  output logic                 write,
  output logic [10:0]          tx_frame,
  output logic [8:0]           x_delta,
  output logic [8:0]           y_delta,
  output logic [2:0]           buttons,
  output logic [POS_WIDTH-1:0] x_pos,
  output logic [POS_WIDTH-1:0] y_pos,
  output logic                 new_out,
  output logic                 ready,
  output logic                 fail,
  output logic [7:0]           pkt_err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_next;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [7:0] retries, rx_byte;
  logic [1:0] idx;
  // header byte without its always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, buttons}
  logic [6:0] hdr;
  logic [7:0] b1;
  logic good, bad, waiting, tmo, accept, sync_drop, gap_hit, apply, load_f4, load_ff;
  always_comb begin
    rx_byte = rx_data[F_DATA_MSB:F_DATA_LSB];
    good = data_available & ~err & ~rx_data[F_START] & rx_data[F_STOP] & (^rx_data[F_PARITY:F_DATA_LSB]);
    bad = data_available & ~good;
    waiting = state == WAIT_BAT || state == WAIT_ID || state == WAIT_ACK;
    tmo = waiting && !data_available && tcnt == TW'(TIMEOUT_CYCLES - 1);
    accept = state == STREAM && good && (idx != 2'd0 || rx_byte[3]);
    sync_drop = state == STREAM && good && idx == 2'd0 && !rx_byte[3];
    gap_hit = state == STREAM && idx != 2'd0 && !data_available && gcnt == GW'(GAP_CYCLES - 1);
    apply = accept && idx == 2'd2;
  end
  always_comb begin
    state_next = state;
    load_f4 = 1'b0;
    load_ff = 1'b0;
    case (state)
      WAIT_BAT, WAIT_ID, WAIT_ACK: begin
        if (good && state == WAIT_BAT && rx_byte == BAT_OK) state_next = WAIT_ID;
        else if (good && state == WAIT_ID && rx_byte == MOUSE_ID) begin
          load_f4 = 1'b1;
          state_next = BUSY_CHECK;
        end else if (good && state == WAIT_ACK && rx_byte == ACK) state_next = STREAM;
        else if (tmo && retries < 8'(MAX_RETRIES)) begin
          load_ff = 1'b1;
          state_next = BUSY_CHECK;
        end else if (tmo) state_next = FAIL;
      end
      BUSY_CHECK: state_next = busy ? BUSY_CHECK : SEND;
      SEND: state_next = tx_frame[F_DATA_MSB:F_DATA_LSB] == EN_REPORTING ? WAIT_ACK : WAIT_BAT;
      default: state_next = state;
    endcase
  end
  assign write = state == SEND;
  assign ready = state == STREAM;
  assign fail = state == FAIL;
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state <= WAIT_BAT;
      tx_frame <= 11'h7FF;
      tcnt <= '0;
      gcnt <= '0;
      retries <= '0;
      idx <= '0;
      hdr <= '0;
      b1 <= '0;
      buttons <= '0;
      new_out <= 1'b0;
      pkt_err_cnt <= '0;
    end else begin
      state <= state_next;
      tcnt <= (state_next != state || !waiting || data_available && tcnt == TW'(TIMEOUT_CYCLES - 1)) ? '0 : tcnt + 1'b1;
      gcnt <= (accept || gap_hit || idx == 2'd0 || data_available && gcnt == GW'(GAP_CYCLES - 1)) ? '0 : gcnt + 1'b1;
      retries <= load_ff ? retries + 1'b1 : (state_next == STREAM && state != STREAM) ? '0 : retries;
      tx_frame <= load_f4 ? mk_frame(EN_REPORTING) : load_ff ? mk_frame(CMD_RESET) : tx_frame;
      idx <= apply || gap_hit ? 2'd0 : accept ? idx + 1'b1 : idx;
      hdr <= accept && idx == 2'd0 ? {rx_byte[7:4], rx_byte[2:0]} : hdr;
      b1 <= accept && idx == 2'd1 ? rx_byte : b1;
      buttons <= apply ? hdr[2:0] : buttons;
      new_out <= apply;
      pkt_err_cnt <= (bad || sync_drop || gap_hit) && pkt_err_cnt != 8'hFF ? pkt_err_cnt + 1'b1 : pkt_err_cnt;
    end
  end
  ps2_axis_accum #(.POS_WIDTH(POS_WIDTH), .MAX(X_MAX), .INIT(POS_INIT_X), .SPEED_SHIFT(SPEED_SHIFT)) u_x (
    .clk_25MHz(clk_25MHz), .reset(reset), .en(apply), .invert(1'b0),
    .sign(hdr[3]), .ovf(hdr[5]), .mag(b1), .delta(x_delta), .pos(x_pos)
  );
  // PS/2 reports up as positive while screen rows grow downwards
  ps2_axis_accum #(.POS_WIDTH(POS_WIDTH), .MAX(Y_MAX), .INIT(POS_INIT_Y), .SPEED_SHIFT(SPEED_SHIFT)) u_y (
    .clk_25MHz(clk_25MHz), .reset(reset), .en(apply), .invert(1'b1),
    .sign(hdr[4]), .ovf(hdr[6]), .mag(rx_byte), .delta(y_delta), .pos(y_pos)
  );
endmodule

// File: tb/tb_ps2_mouse_ctrl_v2.sv
// tb_ps2_mouse_ctrl_v2: directed handshake, packet, clamp, sync, gap, timeout and reset checks.
module tb_ps2_mouse_ctrl_v2;
  localparam int TMO = 200;
  localparam int GAP = 40;
  logic clk_25MHz = 1'b0, reset, data_available, err, busy;
  logic [10:0] rx_data;
  logic write, new_out, ready, fail;
  logic [10:0] tx_frame;
  logic [8:0] x_delta, y_delta;
  logic [2:0] buttons;
  logic [9:0] x_pos, y_pos;
  logic [7:0] pkt_err_cnt;
  int total = 0, bad = 0, pulses;
  always #5 clk_25MHz = ~clk_25MHz;
  ps2_mouse_ctrl_v2 #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .rx_data(rx_data), .data_available(data_available),
    .err(err), .busy(busy), .write(write), .tx_frame(tx_frame), .x_delta(x_delta),
    .y_delta(y_delta), .buttons(buttons), .x_pos(x_pos), .y_pos(y_pos), .new_out(new_out),
    .ready(ready), .fail(fail), .pkt_err_cnt(pkt_err_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_25MHz);
    #1;
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b);
    logic p = 1'b1;
    for (int i = 0; i < 8; i++) p = p ^ b[i];
    return {1'b1, p, b, 1'b0};
  endfunction
  task automatic send_raw(input logic [10:0] f, input logic e);
    rx_data = f;
    err = e;
    data_available = 1'b1;
    idle(1);
    data_available = 1'b0;
    err = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    send_raw(frame(b), 1'b0);
  endtask
  task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0);
    send(b1);
    send(b2);
    chk({tag, "_new_hi"}, new_out, 1);
    idle(1);
    chk({tag, "_new_lo"}, new_out, 0);
  endtask
  initial begin
    reset = 1'b1; busy = 1'b1; data_available = 1'b0; err = 1'b0; rx_data = 11'h7FF;
    idle(3);
    reset = 1'b0;
    chk("rst_tx_frame", tx_frame, 11'h7FF);
    chk("rst_write", write, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_x_pos", x_pos, 320);
    chk("rst_y_pos", y_pos, 240);
    chk("rst_errcnt", pkt_err_cnt, 0);
    chk("rst_new", new_out, 0);
    send(8'hAA);
    send(8'h00);
    idle(3);
    chk("busy_hold_write", write, 0);
    busy = 1'b0;
    idle(1);
    chk("init_write", write, 1);
    chk("init_tx_frame", tx_frame, 11'b10111101000);
    busy = 1'b1;
    idle(1);
    chk("init_write_once", write, 0);
    send(8'h55);
    chk("ack_ignore", ready, 0);
    send(8'hFA);
    chk("ready", ready, 1);
    pkt("p1", 8'h28, 8'h05, 8'hFB);
    chk("p1_xd", x_delta, 9'h005);
    chk("p1_yd", y_delta, 9'h1FB);
    chk("p1_x", x_pos, 325);
    chk("p1_y", y_pos, 245);
    pkt("p2", 8'h08, 8'h00, 8'hFF);
    chk("p2_yd", y_delta, 9'h0FF);
    chk("p2_y_clamp0", y_pos, 0);
    pkt("p3", 8'h28, 8'h00, 8'h01);
    chk("p3_yd", y_delta, 9'h101);
    chk("p3_y", y_pos, 255);
    pkt("p4", 8'h28, 8'h00, 8'h01);
    chk("p4_y_clampmax", y_pos, 479);
    pkt("p5", 8'h58, 8'h00, 8'h00);
    chk("p5_xd_ovf_neg", x_delta, 9'h100);
    chk("p5_x", x_pos, 69);
    pkt("p6", 8'h4F, 8'h00, 8'h00);
    chk("p6_xd_ovf_pos", x_delta, 9'h0FF);
    chk("p6_x", x_pos, 324);
    chk("p6_buttons", buttons, 3'b111);
    pkt("p7", 8'h48, 8'h00, 8'h00);
    chk("p7_x", x_pos, 579);
    pkt("p8", 8'h48, 8'h00, 8'h00);
    chk("p8_x_clampmax", x_pos, 639);
    pkt("p9", 8'h88, 8'h00, 8'h00);
    chk("p9_yd_ovf", y_delta, 9'h0FF);
    chk("p9_y", y_pos, 224);
    chk("p9_buttons", buttons, 3'b000);
    send(8'h00);
    chk("sync_drop_cnt", pkt_err_cnt, 1);
    pkt("p10", 8'h18, 8'hFF, 8'h00);
    chk("p10_xd", x_delta, 9'h1FF);
    chk("p10_x", x_pos, 638);
    send_raw(frame(8'h08) ^ 11'h200, 1'b0);
    chk("parity_cnt", pkt_err_cnt, 2);
    send_raw(frame(8'h08), 1'b1);
    chk("rxerr_cnt", pkt_err_cnt, 3);
    chk("bad_frame_ready", ready, 1);
    pkt("p11", 8'h08, 8'h01, 8'h00);
    chk("p11_x", x_pos, 639);
    send(8'h08);
    send(8'h05);
    pulses = 0;
    for (int i = 0; i < GAP + 10; i++) begin
      idle(1);
      if (new_out) pulses++;
    end
    chk("gap_no_new", pulses, 0);
    chk("gap_cnt", pkt_err_cnt, 4);
    pkt("p12", 8'h18, 8'hFE, 8'h00);
    chk("p12_xd", x_delta, 9'h1FE);
    chk("p12_x", x_pos, 637);
    send(8'h08);
    reset = 1'b1;
    idle(1);
    chk("midpkt_x", x_pos, 320);
    chk("midpkt_y", y_pos, 240);
    chk("midpkt_ready", ready, 0);
    chk("midpkt_cnt", pkt_err_cnt, 0);
    chk("midpkt_xd", x_delta, 0);
    chk("midpkt_tx", tx_frame, 11'h7FF);
    reset = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 3 * TMO && !write; i++) idle(1);
    chk("retry1_write", write, 1);
    chk("retry1_tx", tx_frame, 11'h7FE);
    reset = 1'b1;
    idle(1);
    chk("midretry_tx", tx_frame, 11'h7FF);
    chk("midretry_write", write, 0);
    chk("midretry_fail", fail, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10 * TMO && !fail; i++) begin
      idle(1);
      if (write && tx_frame == 11'h7FE) pulses++;
    end
    chk("retry_sends", pulses, 3);
    chk("fail_set", fail, 1);
    send(8'hAA);
    idle(2);
    chk("fail_sticky", fail, 1);
    chk("fail_ready", ready, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("fail_cleared", fail, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
